// File: rtl/traffic_controller.sv
// traffic_controller
//   Level-driven sequencer for the road lanes. On a level start it writes the
//   per-lane configuration registers one lane per cycle while every car is
//   held in reset, waits one settle cycle, then releases all cars together
//   and gates their movement enable. Also handles pause and game-over.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   clk_enable      : movement tick from the clock divider
//   level_start     : one-cycle pulse, begin loading a level
//   level[2:0]      : level number, sampled on level_start
//   pause           : level-sensitive pause request
//   game_over       : one-cycle pulse, stop traffic
//   car_reset       : per-lane reset to the car instances
//   car_enable      : movement enable to all cars
//   lane_dir        : 2 bits per lane
//   lane_speed      : 6 bits per lane
//   lane_length     : 2 bits per lane
//   lane_start_x/y  : 10 bits per lane
//   running         : high while in RUN
//   load_done       : one-cycle pulse in the first RUN cycle after a load
//   Lane i occupies bits [W*i +: W] of each packed bus.
module traffic_controller #(
  parameter int LANES       = 4,
  parameter int TOP_Y       = 64,
  parameter int LANE_HEIGHT = 32,
  parameter int MIN_SPEED   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 level_start,
  input  logic [2:0]           level,
  input  logic                 pause,
  input  logic                 game_over,
  output logic [LANES-1:0]     car_reset,
  output logic                 car_enable,
  output logic [2*LANES-1:0]   lane_dir,
  output logic [6*LANES-1:0]   lane_speed,
  output logic [2*LANES-1:0]   lane_length,
  output logic [10*LANES-1:0]  lane_start_x,
  output logic [10*LANES-1:0]  lane_start_y,
  output logic                 running,
  output logic                 load_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] PAUSED = 3'd4;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [2:0] idx;
  logic [2:0] level_q;

  // Signed arithmetic in int, floored before narrowing to 6 bits.
  function automatic logic [5:0] speed_for(input int lane, input logic [2:0] lvl);
    int s;
    s = 20 + 4 * lane - 2 * int'(lvl);
    if (s < MIN_SPEED) s = MIN_SPEED;
    return 6'(s);
  endfunction

  always_comb begin
    state_next = state;
    if (level_start) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        LOAD:    if (idx == 3'(LANES - 1)) state_next = SETTLE;
        SETTLE:  state_next = RUN;
        RUN: begin
          if (game_over)  state_next = IDLE;
          else if (pause) state_next = PAUSED;
        end
        PAUSED: begin
          if (game_over)   state_next = IDLE;
          else if (!pause) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign running    = (state == RUN);
  assign car_enable = (state == RUN) && clk_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      level_q      <= '0;
      car_reset    <= '1;
      load_done    <= 1'b0;
      lane_dir     <= '0;
      lane_speed   <= '0;
      lane_length  <= '0;
      lane_start_x <= '0;
      lane_start_y <= '0;
    end else begin
      state <= state_next;
      // Registered from the next state so release and re-assert line up
      // exactly with the RUN/PAUSED boundaries.
      car_reset <= ((state_next == RUN) || (state_next == PAUSED)) ? '0 : '1;
      load_done <= (state == SETTLE) && (state_next == RUN);

      if (level_start) begin
        idx     <= '0;
        level_q <= level;
      end else if (state == LOAD) begin
        idx <= idx + 3'd1;
      end

      if (state == LOAD) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (idx == 3'(i)) begin
            lane_dir[2*i +: 2]      <= {1'b0, i[0]};
            lane_length[2*i +: 2]   <= 2'((i % 3) + 1);
            lane_start_x[10*i +: 10] <= 10'(((5 * i) % 20) * 32);
            lane_start_y[10*i +: 10] <= 10'(TOP_Y + LANE_HEIGHT * int'(i));
            lane_speed[6*i +: 6]    <= speed_for(int'(i), level_q);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_controller.sv
module tb_traffic_controller;

  localparam int LANES = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_enable;
  logic                 level_start;
  logic [2:0]           level;
  logic                 pause;
  logic                 game_over;
  logic [LANES-1:0]     car_reset;
  logic                 car_enable;
  logic [2*LANES-1:0]   lane_dir;
  logic [6*LANES-1:0]   lane_speed;
  logic [2*LANES-1:0]   lane_length;
  logic [10*LANES-1:0]  lane_start_x;
  logic [10*LANES-1:0]  lane_start_y;
  logic                 running;
  logic                 load_done;

  int checks   = 0;
  int failures = 0;

  traffic_controller #(.LANES(LANES), .TOP_Y(64), .LANE_HEIGHT(32), .MIN_SPEED(8)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .level_start(level_start),
    .level(level), .pause(pause), .game_over(game_over), .car_reset(car_reset),
    .car_enable(car_enable), .lane_dir(lane_dir), .lane_speed(lane_speed),
    .lane_length(lane_length), .lane_start_x(lane_start_x), .lane_start_y(lane_start_y),
    .running(running), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference configuration derived directly from the lane rules.
  function automatic int ref_speed(input int i, input int lvl);
    int s = 20 + 4 * i - 2 * lvl;
    return (s < 8) ? 8 : s;
  endfunction

  function automatic logic [63:0] ref_bus(input int field, input int lvl);
    logic [63:0] r = '0;
    for (int i = 0; i < LANES; i++) begin
      case (field)
        0: r[2*i +: 2]   = 2'(i % 2);
        1: r[6*i +: 6]   = 6'(ref_speed(i, lvl));
        2: r[2*i +: 2]   = 2'((i % 3) + 1);
        3: r[10*i +: 10] = 10'(((5 * i) % 20) * 32);
        default: r[10*i +: 10] = 10'(64 + 32 * i);
      endcase
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rst"}, 64'(car_reset), 64'hF);
    check({tag, "_run"}, 64'(running), 64'd0);
    check({tag, "_ld"}, 64'(load_done), 64'd0);
    check({tag, "_en"}, 64'(car_enable), 64'd0);
  endtask

  task automatic check_config(input int lvl);
    check("cfg_dir", 64'(lane_dir), ref_bus(0, lvl));
    check("cfg_spd", 64'(lane_speed), ref_bus(1, lvl));
    check("cfg_len", 64'(lane_length), ref_bus(2, lvl));
    check("cfg_x", 64'(lane_start_x), ref_bus(3, lvl));
    check("cfg_y", 64'(lane_start_y), ref_bus(4, lvl));
  endtask

  // Pulses level_start (optionally with game_over) and checks the whole
  // sequence up to and including the first RUN cycle.
  task automatic do_load(input int lvl, input bit with_go);
    level_start = 1'b1;
    level       = 3'(lvl);
    game_over   = with_go;
    tick();
    level_start = 1'b0;
    game_over   = 1'b0;
    level       = 3'($urandom_range(0, 7));
    for (int c = 1; c <= LANES + 1; c++) begin
      check("load_rst", 64'(car_reset), 64'hF);
      check("load_ld", 64'(load_done), 64'd0);
      check("load_run", 64'(running), 64'd0);
      if (c >= 2) check("lane_spd_inc", 64'(lane_speed[6*(c-2) +: 6]), 64'(ref_speed(c - 2, lvl)));
      tick();
    end
    check("run_ld", 64'(load_done), 64'd1);
    check("run_run", 64'(running), 64'd1);
    check("run_rst", 64'(car_reset), 64'd0);
    check_config(lvl);
  endtask

  task automatic run_enable_phase(input int n);
    for (int k = 0; k < n; k++) begin
      clk_enable = 1'($urandom_range(0, 1));
      #1;
      check("run_en", 64'(car_enable), 64'(clk_enable));
      tick();
      check("run_ld_low", 64'(load_done), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b0; level_start = 1'b0; level = '0;
    pause = 1'b0; game_over = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    check("reset_spd", 64'(lane_speed), 64'd0);
    check("reset_x", 64'(lane_start_x), 64'd0);
    reset = 1'b0;
    tick();
    game_over = 1'b1; pause = 1'b1;
    tick();
    game_over = 1'b0; pause = 1'b0;
    check_idle_outputs("idle_ignore");

    // Level 0 and level 7 with literal spot checks.
    do_load(0, 1'b0);
    check("l0_spd_lit", 64'(lane_speed), {40'd0, 6'd32, 6'd28, 6'd24, 6'd20});
    run_enable_phase(8);
    do_load(7, 1'b0);
    check("l7_spd_lit", 64'(lane_speed), {40'd0, 6'd18, 6'd14, 6'd10, 6'd8});
    run_enable_phase(8);

    // Pause / release.
    clk_enable = 1'b1;
    pause = 1'b1;
    tick();
    for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
      check("pause_en", 64'(car_enable), 64'd0);
      check("pause_run", 64'(running), 64'd0);
      check("pause_rst", 64'(car_reset), 64'd0);
      tick();
    end
    pause = 1'b0;
    tick();
    check("unpause_run", 64'(running), 64'd1);
    check("unpause_ld", 64'(load_done), 64'd0);
    check("unpause_en", 64'(car_enable), 64'd1);

    // Restart mid-LOAD at idx=2.
    level_start = 1'b1; level = 3'($urandom_range(0, 7));
    tick();
    level_start = 1'b0;
    tick(); tick();
    do_load(3, 1'b0);
    check("restart_spd_lit", 64'(lane_speed), {40'd0, 6'd26, 6'd22, 6'd18, 6'd14});

    // level_start wins over game_over in RUN.
    do_load(int'($urandom_range(0, 7)), 1'b1);

    // game_over alone in PAUSED.
    pause = 1'b1;
    tick();
    check("p_run", 64'(running), 64'd0);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_idle_outputs("go_paused");
    tick();
    check_idle_outputs("go_stay_idle");
    pause = 1'b0;

    // pause held across RUN entry: one RUN cycle, then PAUSED.
    pause = 1'b1;
    do_load(int'($urandom_range(0, 7)), 1'b0);
    tick();
    check("pentry_run", 64'(running), 64'd0);
    check("pentry_rst", 64'(car_reset), 64'd0);
    pause = 1'b0;
    tick();
    check("pentry_back", 64'(running), 64'd1);

    // Random levels.
    for (int r = 0; r < 6; r++) begin
      do_load(int'($urandom_range(0, 7)), 1'b0);
      run_enable_phase(int'($urandom_range(1, 4)));
    end

    // Reset during SETTLE.
    level_start = 1'b1; level = 3'($urandom_range(0, 7));
    tick();
    level_start = 1'b0;
    for (int c = 1; c <= LANES; c++) tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_settle");
    check("rst_dir", 64'(lane_dir), 64'd0);
    check("rst_spd", 64'(lane_speed), 64'd0);
    check("rst_len", 64'(lane_length), 64'd0);
    check("rst_x", 64'(lane_start_x), 64'd0);
    check("rst_y", 64'(lane_start_y), 64'd0);
    reset = 1'b0;
    tick();
    check_idle_outputs("rst_after");
    tick();
    check_idle_outputs("rst_after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
